// File: rtl/cam_seq_pkg.sv
// cam_seq_pkg: shared state encoding, geometry defaults and helpers for the frame capture sequencer
package cam_seq_pkg;

    localparam int PIXELS_DEF = 307200;
    localparam int IDX_W      = 19;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_LOAD    = 3'd3,
        S_READ    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_REQ,
        P_VALID,
        P_RELEASE
    } phase_t;

    // A frame request of zero still captures one frame.
    function automatic logic [3:0] frame_target(input logic [3:0] f);
        return (f == 4'd0) ? 4'd1 : f;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer with rise/fall pulses on the synchronized level
// Ports: clk, rst_n (async active-low), d (async input),
//        q (synchronized level), rise/fall (one-cycle edge pulses).
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;
    logic [2:0] v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            v  <= 3'b000;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
            v  <= {v[1:0], 1'b1};
        end
    end

    // Edges are suppressed until both compared samples come from the real
    // input, so a level already high at reset release never looks like a rise.
    assign q    = s2;
    assign rise = v[2] & s2 & ~s3;
    assign fall = v[2] & ~s2 & s3;

endmodule

// File: rtl/frame_capture_sequencer.sv
// frame_capture_sequencer: arms on a start request, captures N camera frames, then hands pixels to the HPS one by one
// Ports: iCLK, iRST_N (async active-low); iSTART_REQ, iABORT, iFVAL (async), iFRAMES, iHPS_ACK;
//        oCAP_START/oCAP_END pulses to the capture unit, oRD_LOAD/oRD_REQ to the SDRAM read port,
//        oPIX_VALID/oPIX_INDEX to the HPS, status oFRAME_CNT, oSTATE, oBUSY, oDONE. All outputs registered.
module frame_capture_sequencer
    import cam_seq_pkg::*;
#(
    parameter int PIXELS      = PIXELS_DEF,
    parameter int LOAD_CYCLES = 4
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART_REQ,
    input  logic             iABORT,
    input  logic             iFVAL,
    input  logic [3:0]       iFRAMES,
    input  logic             iHPS_ACK,
    output logic             oCAP_START,
    output logic             oCAP_END,
    output logic             oRD_LOAD,
    output logic             oRD_REQ,
    output logic             oPIX_VALID,
    output logic [IDX_W-1:0] oPIX_INDEX,
    output logic [3:0]       oFRAME_CNT,
    output logic [2:0]       oSTATE,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PIXELS - 1);

    logic start_q, start_rise, start_fall;
    logic fval_q, fval_rise, fval_fall;
    logic unused_edges;

    sync_edge u_start (.clk(iCLK), .rst_n(iRST_N), .d(iSTART_REQ), .q(start_q), .rise(start_rise), .fall(start_fall));
    sync_edge u_fval  (.clk(iCLK), .rst_n(iRST_N), .d(iFVAL),      .q(fval_q),  .rise(fval_rise),  .fall(fval_fall));

    assign unused_edges = start_fall ^ fval_q;

    state_t           st, st_nx;
    phase_t           ph, ph_nx;
    logic [LW-1:0]    lc, lc_nx;
    logic             cap_start_nx, cap_end_nx, rd_load_nx, rd_req_nx, pix_valid_nx;
    logic [IDX_W-1:0] pix_nx;
    logic [3:0]       cnt_nx;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            st         <= S_IDLE;
            ph         <= P_REQ;
            lc         <= '0;
            oCAP_START <= 1'b0;
            oCAP_END   <= 1'b0;
            oRD_LOAD   <= 1'b0;
            oRD_REQ    <= 1'b0;
            oPIX_VALID <= 1'b0;
            oPIX_INDEX <= '0;
            oFRAME_CNT <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            st         <= st_nx;
            ph         <= ph_nx;
            lc         <= lc_nx;
            oCAP_START <= cap_start_nx;
            oCAP_END   <= cap_end_nx;
            oRD_LOAD   <= rd_load_nx;
            oRD_REQ    <= rd_req_nx;
            oPIX_VALID <= pix_valid_nx;
            oPIX_INDEX <= pix_nx;
            oFRAME_CNT <= cnt_nx;
            oBUSY      <= st_nx inside {S_ARM, S_CAPTURE, S_LOAD, S_READ};
            oDONE      <= st_nx == S_DONE;
        end
    end

    assign oSTATE = st;

    always_comb begin
        st_nx        = st;
        ph_nx        = ph;
        lc_nx        = lc;
        cap_start_nx = 1'b0;
        cap_end_nx   = 1'b0;
        rd_load_nx   = oRD_LOAD;
        rd_req_nx    = 1'b0;
        pix_valid_nx = oPIX_VALID;
        pix_nx       = oPIX_INDEX;
        cnt_nx       = oFRAME_CNT;
        if (iABORT) begin
            st_nx        = S_IDLE;
            cap_end_nx   = (st == S_ARM) || (st == S_CAPTURE);
            rd_load_nx   = 1'b0;
            pix_valid_nx = 1'b0;
        end else begin
            case (st)
                S_IDLE: if (start_rise) begin
                    st_nx  = S_ARM;
                    cnt_nx = '0;
                end
                S_ARM: if (fval_rise) begin
                    st_nx        = S_CAPTURE;
                    cap_start_nx = 1'b1;
                end
                S_CAPTURE: if (fval_fall) begin
                    cnt_nx = oFRAME_CNT + 4'd1;
                    if (cnt_nx >= frame_target(iFRAMES)) begin
                        st_nx      = S_LOAD;
                        cap_end_nx = 1'b1;
                        rd_load_nx = 1'b1;
                        lc_nx      = '0;
                    end
                end
                // oRD_LOAD rises on entry, so LOAD_CYCLES-1 further cycles complete the pulse.
                S_LOAD: if (lc == LW'(LOAD_CYCLES - 1)) begin
                    st_nx      = S_READ;
                    rd_load_nx = 1'b0;
                    pix_nx     = '0;
                    rd_req_nx  = 1'b1;
                    ph_nx      = P_REQ;
                end else begin
                    lc_nx = lc + 1'b1;
                end
                S_READ: case (ph)
                    P_REQ: begin
                        ph_nx        = P_VALID;
                        pix_valid_nx = 1'b1;
                    end
                    P_VALID: if (iHPS_ACK) begin
                        ph_nx        = P_RELEASE;
                        pix_valid_nx = 1'b0;
                    end
                    P_RELEASE: if (!iHPS_ACK) begin
                        if (oPIX_INDEX == LAST) begin
                            st_nx = S_DONE;
                        end else begin
                            pix_nx    = oPIX_INDEX + 1'b1;
                            rd_req_nx = 1'b1;
                            ph_nx     = P_REQ;
                        end
                    end
                    default: ph_nx = P_REQ;
                endcase
                S_DONE: if (!start_q) st_nx = S_IDLE;
                default: st_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// tb_frame_capture_sequencer: randomized self-checking bench for frame_capture_sequencer
module tb_frame_capture_sequencer;

    localparam int PIX = 8;
    localparam int LDC = 4;

    logic        iCLK, iRST_N, iSTART_REQ, iABORT, iFVAL, iHPS_ACK;
    logic [3:0]  iFRAMES;
    logic        oCAP_START, oCAP_END, oRD_LOAD, oRD_REQ, oPIX_VALID, oBUSY, oDONE;
    logic [18:0] oPIX_INDEX;
    logic [3:0]  oFRAME_CNT;
    logic [2:0]  oSTATE;
    logic [32:0] outs;

    frame_capture_sequencer #(.PIXELS(PIX), .LOAD_CYCLES(LDC)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART_REQ(iSTART_REQ), .iABORT(iABORT),
        .iFVAL(iFVAL), .iFRAMES(iFRAMES), .iHPS_ACK(iHPS_ACK),
        .oCAP_START(oCAP_START), .oCAP_END(oCAP_END), .oRD_LOAD(oRD_LOAD), .oRD_REQ(oRD_REQ),
        .oPIX_VALID(oPIX_VALID), .oPIX_INDEX(oPIX_INDEX), .oFRAME_CNT(oFRAME_CNT),
        .oSTATE(oSTATE), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    assign outs = {oCAP_START, oCAP_END, oRD_LOAD, oRD_REQ, oPIX_VALID, oPIX_INDEX, oFRAME_CNT, oSTATE, oBUSY, oDONE};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed behaviour, recorded once per cycle away from the active edge.
    int n_cs = 0, n_ce = 0, n_req = 0, n_load = 0, hs_err = 0, load_run = 0, last_load = 0, ce_cyc = 0;
    logic [18:0] req_idx[$];
    logic p_valid = 1'b0, p_req = 1'b0, ack_e = 1'b0, ab_e = 1'b0;

    always @(posedge iCLK) begin
        ack_e <= iHPS_ACK;
        ab_e  <= iABORT;
    end

    always @(negedge iCLK) begin
        if (oCAP_START) n_cs++;
        if (oCAP_END) begin n_ce++; ce_cyc = cyc; end
        if (oRD_LOAD) load_run++;
        else if (load_run != 0) begin last_load = load_run; n_load++; load_run = 0; end
        if (oRD_REQ) begin n_req++; req_idx.push_back(oPIX_INDEX); end
        if (oPIX_VALID && !p_valid && !p_req) hs_err++;
        if (p_valid && ack_e && oPIX_VALID) hs_err++;
        if (p_valid && !ack_e && !oPIX_VALID && !ab_e) hs_err++;
        p_valid = oPIX_VALID;
        p_req   = oRD_REQ;
    end

    // HPS model: acknowledge a valid pixel after a delay, release once valid drops.
    logic hps_en = 1'b0;
    int   hps_delay = 3;

    initial begin
        int hcnt, cur;
        hcnt = 0;
        cur = 0;
        iHPS_ACK = 1'b0;
        forever begin
            @(negedge iCLK);
            if (!hps_en) begin
                iHPS_ACK = 1'b0;
                hcnt = 0;
                cur = (hps_delay < 0) ? int'($urandom_range(0, 4)) : hps_delay;
            end else if (iHPS_ACK) begin
                if (!oPIX_VALID) begin
                    iHPS_ACK = 1'b0;
                    hcnt = 0;
                    cur = (hps_delay < 0) ? int'($urandom_range(0, 4)) : hps_delay;
                end
            end else if (oPIX_VALID) begin
                hcnt++;
                if (hcnt >= cur) iHPS_ACK = 1'b1;
            end
        end
    end

    int fall_cyc[16];
    int cs0, ce0, req0, load0, hs0, q0;

    task automatic snap();
        cs0 = n_cs; ce0 = n_ce; req0 = n_req; load0 = n_load; hs0 = hs_err; q0 = req_idx.size();
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
        int n = 0;
        while (oSTATE !== s && n < lim) begin
            @(negedge iCLK);
            n++;
        end
        chk(tag, oSTATE, s);
    endtask

    task automatic wait_valid(input int lim, input string tag);
        int n = 0;
        while (oPIX_VALID !== 1'b1 && n < lim) begin
            @(negedge iCLK);
            n++;
        end
        chk(tag, oPIX_VALID, 1'b1);
    endtask

    task automatic fval_train(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(3, 6)) @(negedge iCLK);
            iFVAL = 1'b1;
            repeat ($urandom_range(3, 8)) @(negedge iCLK);
            iFVAL = 1'b0;
            fall_cyc[i] = cyc;
        end
        repeat (3) @(negedge iCLK);
    endtask

    task automatic start_arm(input logic [3:0] fr, input string tag);
        @(negedge iCLK);
        iFRAMES = fr;
        snap();
        iSTART_REQ = 1'b1;
        wait_state(3'd1, 20, tag);
    endtask

    task automatic run_capture(input logic [3:0] fr, input int pulses, input int hdel);
        int exp_f, bad, d;
        exp_f = (fr == 4'd0) ? 1 : int'(fr);
        hps_delay = hdel;
        hps_en = 1'b1;
        start_arm(fr, "arm");
        chk("arm_busy", oBUSY, 1'b1);
        fork
            fval_train(pulses);
            wait_state(3'd5, 500, "reach_done");
        join
        d = ce_cyc - fall_cyc[exp_f - 1];
        chk("cap_start_once", n_cs - cs0, 1);
        chk("cap_end_once", n_ce - ce0, 1);
        chk("cap_end_after_nth_fall", (d >= 2 && d <= 4), 1'b1);
        chk("frame_cnt", oFRAME_CNT, exp_f);
        chk("rd_load_runs", n_load - load0, 1);
        chk("rd_load_len", last_load, LDC);
        chk("rd_req_count", n_req - req0, PIX);
        bad = 0;
        for (int i = 0; i < PIX; i++)
            if (q0 + i >= req_idx.size() || req_idx[q0 + i] != 19'(i)) bad++;
        chk("pix_index_seq", bad, 0);
        chk("pix_index_end", oPIX_INDEX, PIX - 1);
        chk("handshake", hs_err - hs0, 0);
        chk("done_busy", {oBUSY, oDONE}, 2'b01);
        repeat (5) @(negedge iCLK);
        chk("done_held", oDONE, 1'b1);
        iSTART_REQ = 1'b0;
        wait_state(3'd0, 20, "back_idle");
        chk("done_clear", oDONE, 1'b0);
        hps_en = 1'b0;
    endtask

    initial begin
        int idx0;
        iRST_N = 1'b1; iSTART_REQ = 1'b0; iABORT = 1'b0; iFVAL = 1'b0; iFRAMES = 4'd0;
        #2 iRST_N = 1'b0;
        #2 chk("reset_outs", outs, 33'd0);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (5) @(negedge iCLK);
        chk("idle_after_reset", {oSTATE, oBUSY, oDONE}, 5'd0);

        // Two frames requested, three FVAL pulses, HPS acks after 3 cycles.
        run_capture(4'd2, 3, 3);
        // Zero frames requested behaves as one.
        run_capture(4'd0, 2, 3);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] fr;
            fr = 4'($urandom_range(0, 3));
            run_capture(fr, ((fr == 4'd0) ? 1 : int'(fr)) + int'($urandom_range(0, 1)), -1);
        end

        // Abort while capturing.
        start_arm(4'd3, "ab_arm");
        @(negedge iCLK) iFVAL = 1'b1;
        wait_state(3'd2, 10, "ab_capture");
        @(negedge iCLK) iABORT = 1'b1;
        @(negedge iCLK);
        chk("ab_cap_state", oSTATE, 3'd0);
        chk("ab_cap_end", oCAP_END, 1'b1);
        chk("ab_cap_busy", oBUSY, 1'b0);
        iABORT = 1'b0;
        iFVAL = 1'b0;
        @(negedge iCLK);
        chk("ab_cap_end_pulse", oCAP_END, 1'b0);
        iSTART_REQ = 1'b0;
        repeat (5) @(negedge iCLK);

        // Abort while a pixel is presented.
        start_arm(4'd1, "abr_arm");
        fval_train(1);
        wait_valid(40, "abr_valid");
        chk("abr_in_read", oSTATE, 3'd4);
        iABORT = 1'b1;
        @(negedge iCLK);
        chk("abr_state", oSTATE, 3'd0);
        chk("abr_pix_valid", oPIX_VALID, 1'b0);
        chk("abr_no_cap_end", oCAP_END, 1'b0);
        chk("abr_rd_req", oRD_REQ, 1'b0);
        iABORT = 1'b0;
        iSTART_REQ = 1'b0;
        repeat (5) @(negedge iCLK);

        // A fresh start edge during readout changes nothing.
        start_arm(4'd1, "s2_arm");
        fval_train(1);
        wait_valid(40, "s2_valid");
        idx0 = int'(oPIX_INDEX);
        chk("s2_idx_first", idx0, 0);
        iSTART_REQ = 1'b0;
        repeat (5) @(negedge iCLK);
        iSTART_REQ = 1'b1;
        repeat (6) @(negedge iCLK);
        chk("s2_state", oSTATE, 3'd4);
        chk("s2_idx_kept", oPIX_INDEX, idx0);
        chk("s2_valid_kept", oPIX_VALID, 1'b1);
        hps_delay = 1;
        hps_en = 1'b1;
        wait_state(3'd5, 300, "s2_done");
        chk("s2_req_count", n_req - req0, PIX);
        chk("s2_idx_end", oPIX_INDEX, PIX - 1);
        iSTART_REQ = 1'b0;
        wait_state(3'd0, 20, "s2_idle");
        hps_en = 1'b0;

        // Reset in the middle of readout, start held high through release.
        hps_delay = 2;
        hps_en = 1'b1;
        start_arm(4'd1, "rr_arm");
        fval_train(1);
        begin
            int n = 0;
            while (!(oSTATE == 3'd4 && oPIX_INDEX >= 19'd2) && n < 300) begin
                @(negedge iCLK);
                n++;
            end
        end
        chk("rr_progress", (oSTATE == 3'd4 && oPIX_INDEX >= 19'd2), 1'b1);
        @(posedge iCLK);
        #3 iRST_N = 1'b0;
        #1 chk("rr_async_outs", outs, 33'd0);
        hps_en = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (20) @(negedge iCLK);
        chk("rr_stays_idle", {oSTATE, oBUSY}, 4'd0);
        iSTART_REQ = 1'b0;
        repeat (5) @(negedge iCLK);
        run_capture(4'd1, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
